// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry circular buffer of {pc, instr} pairs between
// fetch and decode, with synchronous flush and head-entry predecode.
module if_id_queue #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [PC_WIDTH-1:0]          if_pc_in,
    input  logic [INSTR_WIDTH-1:0]       if_instr_in,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [PC_WIDTH-1:0]          id_pc_out,
    output logic [INSTR_WIDTH-1:0]       id_instr_out,
    output logic [4:0]                   id_GPR_waddr,
    output logic                         id_mem_we,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   push;
    logic                   pop;
    logic [5:0]             opcode;

    // Handshake depends only on registered occupancy; no id_ready -> if_ready path.
    assign if_ready = (count != CNT_W'(DEPTH));
    assign id_valid = (count != '0);
    assign push     = if_valid & if_ready;
    assign pop      = id_valid & id_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= if_pc_in;
                instr_mem[wr_ptr] <= if_instr_in;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty queue presents a NOP with all predecode outputs low.
    assign id_pc_out    = id_valid ? pc_mem[rd_ptr]    : '0;
    assign id_instr_out = id_valid ? instr_mem[rd_ptr] : '0;
    assign opcode       = id_instr_out[31:26];

    always_comb begin
        id_GPR_waddr = '0;
        id_mem_we    = 1'b0;
        if (id_valid) begin
            if (opcode == 6'b000011) begin
                id_GPR_waddr = 5'd31;
            end else if (opcode == 6'b000000) begin
                id_GPR_waddr = id_instr_out[15:11];
            end else begin
                id_GPR_waddr = id_instr_out[20:16];
            end
            id_mem_we = id_instr_out[31] & id_instr_out[29];
        end
    end

endmodule
